eth_tx_scheduler: RTL and testbench

- Shares the single GMII transmit path between NUM_PORTS frame sources, e.g. port 0 = ARP engine, port 1 = UDP engine, port 2+ = future sources.
- Grants one requester at a time using round-robin and muxes that requester's gmii_tx_en/gmii_txd onto the PHY-side GMII.
- Enforces a minimum inter-frame gap after each frame.
- A watchdog reclaims the link from a granted source that never signals done.
- Sits between the protocol engines and the GMII-to-RGMII converter, in the gmii_tx_clk domain.

---
 rtl/eth_tx_sched_pkg.sv | 14 +
 rtl/eth_rr_pick.sv | 32 +++
 rtl/eth_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
// Shared types and limits for the GMII transmit scheduler and its round-robin picker.
package eth_tx_sched_pkg;

  localparam int MAX_PORTS = 8;

  typedef logic [7:0] gmii_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo N.
module eth_rr_pick
  import eth_tx_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Offsets 1..N from the previous winner, so that winner is considered last.
  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      if (k <= N) begin
        idx = int'(last_grant) + k;
        if (idx >= N) idx = idx - N;
        if (!valid && req[IW'(idx)]) begin
          grant[IW'(idx)] = 1'b1;
          valid           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin owner of the shared GMII transmit path with inter-frame gap and watchdog.
// Optional per-port frame and timeout statistics: define ETH_TX_SCHED_STATS_EN.
module eth_tx_scheduler
  import eth_tx_sched_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   port_req,
  input  logic [NUM_PORTS-1:0]   port_done,
  output logic [NUM_PORTS-1:0]   port_sel,
  input  logic [NUM_PORTS-1:0]   port_tx_en,
  input  logic [NUM_PORTS*8-1:0] port_txd,
  output logic                   gmii_tx_en,
  output logic [7:0]             gmii_txd,
  output logic                   busy,
  output logic                   timeout_err
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0] frame_cnt,
  output logic [15:0]             timeout_cnt
`endif
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_RESET = IW'(NUM_PORTS - 1);
  localparam logic [TW-1:0] WDOG_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LIMIT  = GW'(IFG_CYCLES - 1);

  sched_state_t         r_state, w_nextState;
  logic [NUM_PORTS-1:0] r_sel, w_nextSel, w_pickGrant;
  logic [IW-1:0]        r_lastGrant, w_nextLastGrant, w_pickIdx;
  logic [TW-1:0]        r_wdog, w_nextWdog;
  logic [GW-1:0]        r_gap, w_nextGap;
  logic                 w_pickValid, w_doneAccepted, w_timeoutFire;
  logic                 r_timeoutErr;
  logic                 r_txEn, w_muxTxEn;
  gmii_byte_t           r_txd, w_muxTxd;

  eth_rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req        (port_req),
    .last_grant (r_lastGrant),
    .grant      (w_pickGrant),
    .valid      (w_pickValid)
  );

  always_comb begin
    w_pickIdx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_pickGrant[i]) w_pickIdx = IW'(i);
    end
  end

  // r_sel is only nonzero in GRANT, so this never matches a stray done.
  assign w_doneAccepted = |(port_done & r_sel);

  always_comb begin
    w_nextState     = r_state;
    w_nextSel       = r_sel;
    w_nextLastGrant = r_lastGrant;
    w_nextWdog      = r_wdog;
    w_nextGap       = r_gap;
    w_timeoutFire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_nextSel       = w_pickGrant;
          w_nextLastGrant = w_pickIdx;
          w_nextWdog      = '0;
          w_nextState     = GRANT;
        end
      end
      GRANT: begin
        if (w_doneAccepted) begin
          w_nextSel   = '0;
          w_nextGap   = '0;
          w_nextState = GAP;
        end else if (r_wdog == WDOG_LIMIT) begin
          w_nextSel     = '0;
          w_nextGap     = '0;
          w_timeoutFire = 1'b1;
          w_nextState   = GAP;
        end else begin
          w_nextWdog = r_wdog + 1'b1;
        end
      end
      GAP: begin
        if (r_gap == GAP_LIMIT) w_nextState = IDLE;
        else                    w_nextGap   = r_gap + 1'b1;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_muxTxEn = 1'b0;
    w_muxTxd  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_sel[i]) begin
        w_muxTxEn = w_muxTxEn | port_tx_en[i];
        w_muxTxd  = w_muxTxd  | port_txd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_lastGrant  <= LAST_RESET;
      r_wdog       <= '0;
      r_gap        <= '0;
      r_timeoutErr <= 1'b0;
      r_txEn       <= 1'b0;
      r_txd        <= '0;
    end else begin
      r_state      <= w_nextState;
      r_sel        <= w_nextSel;
      r_lastGrant  <= w_nextLastGrant;
      r_wdog       <= w_nextWdog;
      r_gap        <= w_nextGap;
      r_timeoutErr <= w_timeoutFire;
      r_txEn       <= w_muxTxEn;
      r_txd        <= w_muxTxd;
    end
  end

  assign port_sel    = r_sel;
  assign gmii_tx_en  = r_txEn;
  assign gmii_txd    = r_txd;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeoutErr;

`ifdef ETH_TX_SCHED_STATS_EN
  logic [NUM_PORTS-1:0][15:0] r_frameCnt;
  logic [15:0]                r_timeoutCnt;

  // Frame counters wrap; the timeout counter sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameCnt   <= '0;
      r_timeoutCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_doneAccepted && r_sel[i]) r_frameCnt[i] <= r_frameCnt[i] + 16'd1;
      end
      if (w_timeoutFire && r_timeoutCnt != 16'hFFFF) r_timeoutCnt <= r_timeoutCnt + 16'd1;
    end
  end

  assign frame_cnt   = r_frameCnt;
  assign timeout_cnt = r_timeoutCnt;
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Randomized scoreboard bench for eth_tx_scheduler against a timeline-based reference model.
module tb_eth_tx_scheduler;

  localparam int N   = 3;
  localparam int IFG = 12;
  localparam int TMO = 4096;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   port_req   = '0;
  logic [N-1:0]   port_done  = '0;
  logic [N-1:0]   port_tx_en = '0;
  logic [N*8-1:0] port_txd   = '0;
  logic [N-1:0]   port_sel;
  logic           gmii_tx_en;
  logic [7:0]     gmii_txd;
  logic           busy;
  logic           timeout_err;
`ifdef ETH_TX_SCHED_STATS_EN
  logic [N*16-1:0] frame_cnt;
  logic [15:0]     timeout_cnt;
`endif

  eth_tx_scheduler #(
    .NUM_PORTS      (N),
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .port_req    (port_req),
    .port_done   (port_done),
    .port_sel    (port_sel),
    .port_tx_en  (port_tx_en),
    .port_txd    (port_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  // 125 MHz gmii_tx_clk
  always #4 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    logic         en;
    logic [7:0]   txd;
    logic         busy;
    logic         terr;
`ifdef ETH_TX_SCHED_STATS_EN
    logic [N*16-1:0] fcnt;
    logic [15:0]     tcnt;
`endif
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: who owns the link, and the first cycle arbitration may run again.
  int mOwner = -1;
  int mLast  = N - 1;
  int mFree  = 0;
  int mGrant = 0;
  int cyc    = 0;
  int mFrames[N];
  int mTimeouts = 0;

  // Source behaviour: 0 quiet, 1 requesting, 2 transmitting.
  int srcState[N];
  int srcLen[N];
  bit srcHang[N];
  int reqPct      = 30;
  int hangBudget  = 0;
  int exactBudget = 0;

  // Drives one cycle of inputs at the falling edge and queues what the
  // outputs must look like after the following rising edge.
  task automatic applyStimulus(input bit doRst);
    logic [N-1:0]   req, done, en;
    logic [N*8-1:0] txd;
    exp_t           e;
    int             win;
    @(negedge clk);
    req  = '0;
    done = '0;
    en   = '0;
    txd  = '0;
    for (int p = 0; p < N; p++) begin
      txd[8*p +: 8] = 8'($urandom);
      if (doRst) begin
        srcState[p] = 0;
        en[p]       = ($urandom_range(3) == 0);
      end else if (mOwner == p) begin
        srcState[p] = 2;
        en[p]       = 1'b1;
        srcLen[p]--;
        if (srcLen[p] == 0 && !srcHang[p]) begin
          done[p]     = 1'b1;
          srcState[p] = 0;
        end
      end else begin
        if (srcState[p] == 2) srcState[p] = 0;
        en[p]   = ($urandom_range(3) == 0);
        done[p] = ($urandom_range(15) == 0);
        if (srcState[p] == 0 && $urandom_range(99) < reqPct) begin
          srcState[p] = 1;
          srcLen[p]   = $urandom_range(64, 1);
          srcHang[p]  = 1'b0;
          if (hangBudget > 0) begin
            srcHang[p] = 1'b1;
            hangBudget--;
          end else if (exactBudget > 0) begin
            srcLen[p] = TMO;
            exactBudget--;
          end
        end else if (srcState[p] == 1 && $urandom_range(199) == 0) begin
          srcState[p] = 0;
        end
        if (srcState[p] == 1) req[p] = 1'b1;
      end
    end
    rst        = doRst;
    port_req   = req;
    port_done  = done;
    port_tx_en = en;
    port_txd   = txd;

    e.sel  = '0;
    e.en   = 1'b0;
    e.txd  = '0;
    e.terr = 1'b0;
    if (doRst) begin
      mOwner    = -1;
      mLast     = N - 1;
      mFree     = cyc + 1;
      mTimeouts = 0;
      for (int p = 0; p < N; p++) mFrames[p] = 0;
    end else begin
      if (mOwner >= 0) begin
        e.en  = en[mOwner];
        e.txd = txd[8*mOwner +: 8];
      end
      if (mOwner < 0) begin
        if (cyc >= mFree && req != '0) begin
          win = -1;
          for (int k = 1; k <= N; k++) begin
            if (win < 0 && req[(mLast + k) % N]) win = (mLast + k) % N;
          end
          mOwner = win;
          mLast  = win;
          mGrant = cyc + 1;
        end
      end else if (done[mOwner]) begin
        mFrames[mOwner] = (mFrames[mOwner] + 1) % 65536;
        mOwner = -1;
        mFree  = cyc + 1 + IFG;
      end else if (cyc - mGrant == TMO - 1) begin
        e.terr = 1'b1;
        if (mTimeouts < 65535) mTimeouts++;
        mOwner = -1;
        mFree  = cyc + 1 + IFG;
      end
    end
    if (mOwner >= 0) e.sel[mOwner] = 1'b1;
    e.busy = (mOwner >= 0) || (cyc + 1 < mFree);
`ifdef ETH_TX_SCHED_STATS_EN
    for (int p = 0; p < N; p++) e.fcnt[16*p +: 16] = 16'(mFrames[p]);
    e.tcnt = 16'(mTimeouts);
`endif
    expQ.push_back(e);
    cyc++;
  endtask

  task automatic checkField(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("port_sel",    48'(port_sel),    48'(e.sel));
    checkField("gmii_tx_en",  48'(gmii_tx_en),  48'(e.en));
    checkField("gmii_txd",    48'(gmii_txd),    48'(e.txd));
    checkField("busy",        48'(busy),        48'(e.busy));
    checkField("timeout_err", 48'(timeout_err), 48'(e.terr));
`ifdef ETH_TX_SCHED_STATS_EN
    checkField("frame_cnt",   48'(frame_cnt),   48'(e.fcnt));
    checkField("timeout_cnt", 48'(timeout_cnt), 48'(e.tcnt));
`endif
  endtask

  // Monitor: pops one expectation per rising edge, sampled just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Main sequence: reset, random traffic, a hung source, a done landing on
  // the last watchdog cycle, a mid-frame reset, then saturated requests.
  initial begin
    $display("[TB] eth_tx_scheduler bench starting");
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    reqPct = 30;
    repeat (800) applyStimulus(1'b0);
    reqPct     = 60;
    hangBudget = 1;
    repeat (4400) applyStimulus(1'b0);
    exactBudget = 1;
    repeat (4400) applyStimulus(1'b0);
    for (int t = 0; t < 300 && !(mOwner >= 0 && cyc - mGrant > 3); t++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (300) applyStimulus(1'b0);
    reqPct = 95;
    repeat (1500) applyStimulus(1'b0);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
